// File: rtl/gate_pipe_fifo.sv
// gate_pipe_fifo: a bitwise logic unit feeding a DEPTH-entry result FIFO.
// Both sides use a valid/ready handshake.
// Optional feature macro: GATE_PIPE_FIFO_REDUCE_EN. When it is defined, the
// block adds the out_red port: {^out_data, |out_data, &out_data} of the head.
module gate_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         done_cnt
`ifdef GATE_PIPE_FIFO_REDUCE_EN
  ,
  output logic [2:0]               out_red
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Bitwise operation selected by op. All eight codes are defined.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      OP_PASS: r = a;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Parity, any-set and all-set reductions of one result word.
  function automatic logic [2:0] reduce_word(input logic [WIDTH-1:0] d);
    return {^d, |d, &d};
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] result_s;

  // Handshake qualifiers. Ready and valid depend only on the registered level.
  always_comb begin
    in_ready_s  = (level_q != LVL_FULL);
    out_valid_s = (level_q != LVL_ZERO);
    push_s      = in_valid & in_ready_s;
    pop_s       = out_ready & out_valid_s;
    result_s    = apply_op(in_a, in_b, in_op);
  end

  // Next-state values for the pointers, the occupancy and the pop counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    done_cnt_d = done_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      done_cnt_d = done_cnt_q + CNT_ONE;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      done_cnt_d = done_cnt_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control state registers. Reset takes priority over any push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LVL_ZERO;
      done_cnt_q <= CNT_ZERO;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Result storage. A push writes the computed result into the tail entry.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= result_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign done_cnt  = done_cnt_q;

`ifdef GATE_PIPE_FIFO_REDUCE_EN
  logic [2:0] out_red_s;

  // Head reductions. They are forced to zero while the FIFO is empty.
  always_comb begin
    out_red_s = 3'b000;
    if (out_valid_s) begin
      out_red_s = reduce_word(mem_q[rd_ptr_q]);
    end else begin
      out_red_s = 3'b000;
    end
  end

  assign out_red = out_red_s;
`endif

endmodule

// File: tb/tb_gate_pipe_fifo.sv
// Self-checking bench for gate_pipe_fifo (WIDTH=8, DEPTH=4, CNT_W=4).
// The bench runs table vectors, a few hand-written corner sequences and a
// randomized phase. All phases are checked against a queue-based model.
module tb_gate_pipe_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    level;
  logic [CW-1:0] done_cnt;
`ifdef GATE_PIPE_FIFO_REDUCE_EN
  logic [2:0]    out_red;
`endif

  gate_pipe_fifo #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level),
    .done_cnt(done_cnt)
`ifdef GATE_PIPE_FIFO_REDUCE_EN
    ,
    .out_red(out_red)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a queue of results and a pop counter.
  logic [W-1:0]  mdl_q[$];
  logic [CW-1:0] mdl_cnt = 4'd0;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model using the inputs that the DUT samples at the coming edge.
  task automatic model_edge();
    bit do_push;
    bit do_pop;
    if (rst) begin
      mdl_q.delete();
      mdl_cnt = 4'd0;
    end else begin
      do_push = in_valid && (mdl_q.size() < D);
      do_pop  = out_ready && (mdl_q.size() > 0);
      if (do_pop) begin
        void'(mdl_q.pop_front());
        mdl_cnt = mdl_cnt + 4'd1;
      end
      if (do_push) mdl_q.push_back(ref_op(in_a, in_b, in_op));
    end
  endtask

  task automatic check_all();
    chk("level", {29'd0, level}, mdl_q.size());
    chk("in_ready", {31'd0, in_ready}, {31'd0, (mdl_q.size() < D)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mdl_q.size() > 0)});
    chk("done_cnt", {28'd0, done_cnt}, {28'd0, mdl_cnt});
    if (mdl_q.size() > 0) chk("out_data", {24'd0, out_data}, {24'd0, mdl_q[0]});
`ifdef GATE_PIPE_FIFO_REDUCE_EN
    if (mdl_q.size() > 0)
      chk("out_red", {29'd0, out_red}, {29'd0, ^mdl_q[0], |mdl_q[0], &mdl_q[0]});
    else
      chk("out_red_empty", {29'd0, out_red}, 32'd0);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] op, input logic ordy);
    rst = r; in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
  endtask

  typedef struct {
    logic          rst;
    logic          vld;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          ordy;
    logic [2:0]    e_level;
    logic          e_valid;
    logic          e_rdy;
    logic [W-1:0]  e_data;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [2:0] op, input logic ordy,
                              input logic [2:0] el, input logic ev, input logic er,
                              input logic [W-1:0] ed, input logic [CW-1:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.a = a; t.b = b; t.op = op; t.ordy = ordy;
    t.e_level = el; t.e_valid = ev; t.e_rdy = er; t.e_data = ed; t.e_cnt = ec;
    return t;
  endfunction

  logic [W-1:0]  op_res [8];
  logic [CW-1:0] cnt_before;

  initial begin
    drive(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    op_res[0] = 8'h48; op_res[1] = 8'hDE; op_res[2] = 8'h96; op_res[3] = 8'hB7;
    op_res[4] = 8'h21; op_res[5] = 8'h69; op_res[6] = 8'h35; op_res[7] = 8'hCA;

    // Reset, then ops 0..7 back to back with the consumer always ready.
    tbl[0] = mk(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 4'd0);
    for (int i = 0; i < 8; i++)
      tbl[1+i] = mk(1'b0, 1'b1, 8'hCA, 8'h5C, 3'(i), 1'b1, 3'd1, 1'b1, 1'b1, op_res[i], 4'(i));
    tbl[9] = mk(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 4'd8);
    // Fill to full with the consumer stalled; the fifth set is held back.
    tbl[10] = mk(1'b0, 1'b1, 8'h11, 8'h00, 3'd7, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11, 4'd8);
    tbl[11] = mk(1'b0, 1'b1, 8'h22, 8'h00, 3'd7, 1'b0, 3'd2, 1'b1, 1'b1, 8'h11, 4'd8);
    tbl[12] = mk(1'b0, 1'b1, 8'h33, 8'h00, 3'd7, 1'b0, 3'd3, 1'b1, 1'b1, 8'h11, 4'd8);
    tbl[13] = mk(1'b0, 1'b1, 8'h44, 8'h00, 3'd7, 1'b0, 3'd4, 1'b1, 1'b0, 8'h11, 4'd8);
    tbl[14] = mk(1'b0, 1'b1, 8'h55, 8'h00, 3'd7, 1'b0, 3'd4, 1'b1, 1'b0, 8'h11, 4'd8);
    tbl[15] = mk(1'b0, 1'b1, 8'h55, 8'h00, 3'd7, 1'b1, 3'd3, 1'b1, 1'b1, 8'h22, 4'd9);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].ordy);
      step();
      chk("tbl_level", {29'd0, level}, {29'd0, tbl[i].e_level});
      chk("tbl_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
      chk("tbl_in_ready", {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      chk("tbl_done_cnt", {28'd0, done_cnt}, {28'd0, tbl[i].e_cnt});
      if (tbl[i].e_valid) chk("tbl_out_data", {24'd0, out_data}, {24'd0, tbl[i].e_data});
    end

    // Drop to level 2, then push and pop together for ten cycles.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step();
    cnt_before = mdl_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
      step();
      chk("sim_level", {29'd0, level}, 32'd2);
    end
    chk("sim_cnt_delta", {28'd0, done_cnt}, {28'd0, cnt_before + 4'd10});

    // Latency: drain to empty, then a single push becomes visible one edge later.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step();
    step();
    chk("lat_pre_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 1'b1, 8'hFF, 8'h0F, 3'd0, 1'b0);
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {24'd0, out_data}, 32'h0F);

    // Reset mid-stream at level 3 with a push and a pop also requested.
    drive(1'b0, 1'b1, 8'hA5, 8'h00, 3'd7, 1'b0);
    step();
    step();
    chk("mid_level3", {29'd0, level}, 32'd3);
    drive(1'b1, 1'b1, 8'h5A, 8'h00, 3'd7, 1'b1);
    step();
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", {28'd0, done_cnt}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Counter wrap: 17 pops on a 4-bit counter leave it at 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 8'(i), 8'h00, 3'd7, 1'b0);
      step();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      step();
    end
    chk("wrap_cnt", {28'd0, done_cnt}, 32'd1);

`ifdef GATE_PIPE_FIFO_REDUCE_EN
    drive(1'b0, 1'b1, 8'hFF, 8'h00, 3'd7, 1'b0);
    step();
    chk("red_ff", {29'd0, out_red}, 32'd3);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'h00, 8'h00, 3'd7, 1'b0);
    step();
    chk("red_00", {29'd0, out_red}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step();
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) != 0), 8'($urandom), 8'($urandom),
            3'($urandom), ($urandom_range(2) != 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
